pll_reset_sequencer: RTL

Controls the system PLL's reset input and gates the reset of every downstream clock domain. Runs on the free-running 50 MHz board reference clock, not on a PLL output. Sequence:
- holds the PLL in reset, then waits for lock;
- qualifies the lock as stable, then releases per-domain resets in a fixed staggered order;
- re-runs the sequence on lock loss, with a bounded retry count and a sticky failure flag.

---
 rtl/pll_reset_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer.
// Holds the system PLL in reset, waits for lock, and qualifies the lock as
// stable. It then releases the downstream domain resets one at a time in a
// fixed staggered order. Lock loss re-runs the sequence. Lock timeouts are
// counted, and too many of them park the block in a sticky FAIL state.
// Runs on the free-running reference clock only.
//
// Ports:
//   refclk      in   reference clock, the only clock
//   rst_n       in   asynchronous active-low reset
//   pll_locked  in   PLL lock indicator, asynchronous to refclk
//   restart_req in   single-cycle request to rerun the whole sequence
//   pll_rst     out  active-high PLL reset
//   domain_rst  out  active-high per-domain resets (consumers resync their bit)
//   ready       out  high only while in RUN
//   fail        out  sticky failure flag
//   retries     out  lock timeouts since the last clear
//   state       out  current FSM state (debug)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RESET_PLL | PLL held in reset for RST_CYCLES, all domains in reset
// WAIT_LOCK | PLL released, waiting for synchronized lock, timeout armed
// STABLE    | counting consecutive locked cycles
// RELEASE   | dropping domain resets every STAGGER_CYCLES, lowest bit first
// RUN       | all domains out of reset, ready high
// FAIL      | too many timeouts; only restart_req or rst_n leaves

module pll_reset_sequencer #(
   parameter int RST_CYCLES     = 16,
   parameter int LOCK_TIMEOUT   = 500000,
   parameter int STABLE_CYCLES  = 1024,
   parameter int NUM_DOMAINS    = 4,
   parameter int STAGGER_CYCLES = 8,
   parameter int MAX_RETRIES    = 3
) (
   input  logic                               refclk,
   input  logic                               rst_n,
   input  logic                               pll_locked,
   input  logic                               restart_req,
   output logic                               pll_rst,
   output logic [NUM_DOMAINS-1:0]             domain_rst,
   output logic                               ready,
   output logic                               fail,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   retries,
   output logic [2:0]                         state
);

   // One shared cycle timer counts time spent in the current state. It must
   // be wide enough for the longest stage.
   localparam int REL_CYCLES = (NUM_DOMAINS - 1) * STAGGER_CYCLES + 1;
   localparam int MAX_A      = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_B      = (STABLE_CYCLES > REL_CYCLES) ? STABLE_CYCLES : REL_CYCLES;
   localparam int TMR_MAX    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int TW         = $clog2(TMR_MAX + 1);
   localparam int RW         = $clog2(MAX_RETRIES + 1);

   localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
   localparam logic [TW-1:0] RELEASE_LAST = TW'(REL_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

   typedef enum logic [2:0] {
      ST_RESET_PLL = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAIL      = 3'd5
   } state_t;

   state_t                  state_q, state_nxt;
   logic [TW-1:0]           tmr, tmr_nxt;
   logic [RW-1:0]           retries_nxt, retries_inc;
   logic                    sync_1, lock_s;
   logic                    pll_rst_nxt, ready_nxt, fail_nxt;
   logic [NUM_DOMAINS-1:0]  domain_rst_nxt;

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1 <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         sync_1 <= pll_locked;
         lock_s <= sync_1;
      end
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_RESET_PLL;
         tmr        <= '0;
         retries    <= '0;
         pll_rst    <= 1'b1;
         domain_rst <= '1;
         ready      <= 1'b0;
         fail       <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         tmr        <= tmr_nxt;
         retries    <= retries_nxt;
         pll_rst    <= pll_rst_nxt;
         domain_rst <= domain_rst_nxt;
         ready      <= ready_nxt;
         fail       <= fail_nxt;
      end
   end

   always_comb begin
      state_nxt      = state_q;
      retries_nxt    = retries;
      retries_inc    = (retries == RETRY_LIMIT) ? retries : retries + RW'(1);
      tmr_nxt        = '0;
      domain_rst_nxt = '1;

      case (state_q)
         ST_RESET_PLL: begin
            if (tmr == RST_LAST) state_nxt = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (lock_s) begin
               state_nxt = ST_STABLE;
            end else if (tmr == TIMEOUT_LAST) begin
               retries_nxt = retries_inc;
               state_nxt   = (retries_inc == RETRY_LIMIT) ? ST_FAIL : ST_RESET_PLL;
            end
         end
         ST_STABLE: begin
            if (!lock_s)                 state_nxt = ST_WAIT_LOCK;
            else if (tmr == STABLE_LAST) state_nxt = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (!lock_s) begin
               state_nxt = ST_RESET_PLL;
            end else if (tmr == RELEASE_LAST) begin
               state_nxt   = ST_RUN;
               retries_nxt = '0;
            end
         end
         ST_RUN: begin
            if (!lock_s) state_nxt = ST_RESET_PLL;
         end
         ST_FAIL: begin
            state_nxt = ST_FAIL;
         end
         default: state_nxt = ST_RESET_PLL;
      endcase

      if (restart_req) begin
         state_nxt   = ST_RESET_PLL;
         retries_nxt = '0;
      end

      // Timer restarts on every state change (and on restart, which also
      // re-arms RESET_PLL); it is parked at zero in the terminal states.
      if (!(restart_req || state_nxt != state_q ||
            state_q == ST_RUN || state_q == ST_FAIL))
         tmr_nxt = tmr + TW'(1);

      // Outputs are decoded from the next state and timer so the registered
      // outputs line up with the registered state.
      pll_rst_nxt = (state_nxt == ST_RESET_PLL) || (state_nxt == ST_FAIL);
      ready_nxt   = (state_nxt == ST_RUN);
      fail_nxt    = (state_nxt == ST_FAIL);

      if (state_nxt == ST_RUN) begin
         domain_rst_nxt = '0;
      end else if (state_nxt == ST_RELEASE) begin
         for (int i = 0; i < NUM_DOMAINS; i++)
            if (tmr_nxt >= TW'(i * STAGGER_CYCLES)) domain_rst_nxt[i] = 1'b0;
      end
   end

   assign state = state_q;

endmodule
